// File: rtl/cgp_feature_sequencer_if.sv
// Feature-in / result-out stream bundle for the CGP classifier sequencer.
// slave is the sequencer side, master the producer/consumer side.
interface cgp_feature_sequencer_if #(
    parameter int FEAT_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [FEAT_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_class;
    logic              m_err;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
endinterface

// File: rtl/cgp_feature_sequencer.sv
// Quantizes three feature beats into classifier operands, waits a settle
// window, captures the decision and returns it with framing/status counters.
module cgp_feature_sequencer #(
    parameter int FEAT_W        = 8,
    parameter int Q_W           = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cgp_feature_sequencer_if.slave bus,
    output logic [Q_W-1:0]        input_a,
    output logic [Q_W-1:0]        input_b,
    output logic [Q_W-1:0]        input_c,
    input  logic                  cgp_out,
    output logic [CNT_W-1:0]      cnt_samples,
    output logic [CNT_W-1:0]      cnt_err
);
    localparam int SH   = FEAT_W - Q_W;
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [FEAT_W:0] RND  = (FEAT_W+1)'((2 ** SH) / 2);
    localparam logic [FEAT_W:0] QMAX = (FEAT_W+1)'((2 ** Q_W) - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_DRAIN,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [SC_W-1:0] cnt_q, cnt_d;
    logic [Q_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic            cls_q, cls_d, err_q, err_d;
    logic [CNT_W-1:0] cs_q, cs_d, ce_q, ce_d;
    logic [FEAT_W:0] q_sum, q_shr;
    logic [Q_W-1:0]  q_val;
    logic            s_ready;

    // Round to nearest, clamp the top code that rounding can overflow into
    always_comb begin
        q_sum = {1'b0, bus.s_data} + RND;
        q_shr = q_sum >> SH;
        q_val = (q_shr > QMAX) ? QMAX[Q_W-1:0] : q_shr[Q_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cls_d   = cls_q;
        err_d   = err_q;
        cs_d    = cs_q;
        ce_d    = ce_q;
        s_ready = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (bus.s_valid) begin
                    if (bus.s_last && idx_q != 2'd2) begin
                        state_d = ST_OUT;
                        cls_d   = 1'b0;
                        err_d   = 1'b1;
                        idx_d   = 2'd0;
                    end else if (!bus.s_last && idx_q == 2'd2) begin
                        state_d = ST_DRAIN;
                        idx_d   = 2'd0;
                    end else begin
                        unique case (idx_q)
                            2'd0:    a_d = q_val;
                            2'd1:    b_d = q_val;
                            default: c_d = q_val;
                        endcase
                        if (idx_q == 2'd2) begin
                            state_d = ST_SETTLE;
                            cnt_d   = SC_W'(SETTLE_CYCLES);
                            idx_d   = 2'd0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (bus.s_valid && bus.s_last) begin
                    state_d = ST_OUT;
                    cls_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - SC_W'(1);
                if (cnt_q == SC_W'(1)) begin
                    state_d = ST_OUT;
                    cls_d   = cgp_out;
                    err_d   = 1'b0;
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    state_d = ST_LOAD;
                    idx_d   = 2'd0;
                    if (err_q) begin
                        ce_d = (ce_q != '1) ? ce_q + CNT_W'(1) : ce_q;
                    end else begin
                        cs_d = (cs_q != '1) ? cs_q + CNT_W'(1) : cs_q;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cls_q   <= 1'b0;
            err_q   <= 1'b0;
            cs_q    <= '0;
            ce_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            ce_q    <= ce_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = (state_q == ST_OUT);
    assign bus.m_class  = cls_q;
    assign bus.m_err    = err_q;
    assign input_a      = a_q;
    assign input_b      = b_q;
    assign input_c      = c_q;
    assign cnt_samples  = cs_q;
    assign cnt_err      = ce_q;
endmodule

// File: tb/tb_cgp_feature_sequencer.sv
// Bench for cgp_feature_sequencer: directed frames plus random traffic,
// checked each cycle against a frame-level reference model.
module tb_cgp_feature_sequencer;
    localparam int SC  = 3;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] input_a, input_b, input_c;
    logic cgp_out;
    logic [CW-1:0] cnt_samples, cnt_err;

    cgp_feature_sequencer_if #(.FEAT_W(8)) bus ();

    cgp_feature_sequencer #(
        .FEAT_W(8), .Q_W(3), .SETTLE_CYCLES(SC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .input_a(input_a), .input_b(input_b), .input_c(input_c),
        .cgp_out(cgp_out),
        .cnt_samples(cnt_samples), .cnt_err(cnt_err)
    );

    // Stand-in classifier: "sum of operands exceeds 7"
    assign cgp_out = (5'(input_a) + 5'(input_b) + 5'(input_c)) > 5'd7;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int mr_mode = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int quant(input int x);
        int q;
        q = (x + 16) / 32;
        return (q > 7) ? 7 : q;
    endfunction

    // Reference model: frame progress, pending result and counters
    int ea, eb, ec, nbeat, settle, cs, ce;
    bit drop, pend, ecls, eerr;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                ea = 0; eb = 0; ec = 0; nbeat = 0; settle = 0;
                cs = 0; ce = 0; drop = 0; pend = 0; ecls = 0; eerr = 0;
            end else if (pend) begin
                if (bus.m_ready) begin
                    pend = 0;
                    if (eerr) ce++; else cs++;
                end
            end else if (settle > 0) begin
                settle--;
                if (settle == 0) begin
                    pend = 1;
                    eerr = 0;
                    ecls = (ea + eb + ec) > 7;
                end
            end else if (bus.s_valid) begin
                if (drop) begin
                    if (bus.s_last) begin
                        drop = 0; pend = 1; eerr = 1; ecls = 0;
                    end
                end else if (bus.s_last && nbeat < 2) begin
                    nbeat = 0; pend = 1; eerr = 1; ecls = 0;
                end else if (!bus.s_last && nbeat == 2) begin
                    nbeat = 0; drop = 1;
                end else begin
                    case (nbeat)
                        0: ea = quant(int'(bus.s_data));
                        1: eb = quant(int'(bus.s_data));
                        default: ec = quant(int'(bus.s_data));
                    endcase
                    if (nbeat == 2) begin
                        nbeat = 0;
                        settle = SC;
                    end else begin
                        nbeat++;
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("s_ready", bus.s_ready, (!pend && settle == 0));
                chk("m_valid", bus.m_valid, pend);
                chk("input_a", input_a, ea);
                chk("input_b", input_b, eb);
                chk("input_c", input_c, ec);
                chk("cnt_samples", cnt_samples, (cs > SAT) ? SAT : cs);
                chk("cnt_err", cnt_err, (ce > SAT) ? SAT : ce);
                if (pend) begin
                    chk("m_class", bus.m_class, ecls);
                    chk("m_err", bus.m_err, eerr);
                end
            end
        end
    end

    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (mr_mode)
                0: bus.m_ready = 1'($urandom_range(0, 1));
                1: bus.m_ready = 1'b1;
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: s_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_valid && n < 50);
        if (!bus.m_valid) begin
            checks++;
            failures++;
            $display("FAIL mvalid_timeout: m_valid got 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", bus.s_ready, 1);
    endtask

    int n;
    int len;
    int r;

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_ops", {input_a, input_b, input_c}, 0);
        chk("rst_cnt", {cnt_samples, cnt_err}, 0);

        // Good sample
        mr_mode = 1;
        send(8'hFF, 1'b0);
        send(8'h40, 1'b0);
        send(8'h00, 1'b1);
        wait_mvalid(n);
        chk("good_latency", n, 4);
        chk("good_ops", {input_a, input_b, input_c}, {3'd7, 3'd2, 3'd0});
        chk("good_class", bus.m_class, 1);
        chk("good_err", bus.m_err, 0);
        @(negedge clk);
        chk("good_cnt", cnt_samples, 1);

        // Zero sample
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h00, 1'b1);
        wait_mvalid(n);
        chk("zero_ops", {input_a, input_b, input_c}, 0);
        chk("zero_class", bus.m_class, 0);
        chk("zero_err", bus.m_err, 0);

        // Short frame: beat 0 written, terminating beat 1 is not
        wait_idle();
        send(8'h80, 1'b0);
        send(8'h20, 1'b1);
        @(negedge clk);
        chk("short_valid", bus.m_valid, 1);
        chk("short_err", bus.m_err, 1);
        chk("short_class", bus.m_class, 0);
        chk("short_ops", {input_a, input_b, input_c}, {3'd4, 3'd0, 3'd0});
        @(negedge clk);
        chk("short_cnt", cnt_err, 1);

        // Long frame then a good sample
        wait_idle();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        send(8'h50, 1'b1);
        @(negedge clk);
        chk("long_err", bus.m_err, 1);
        chk("long_ops", {input_a, input_b, input_c}, {3'd1, 3'd1, 3'd0});
        wait_idle();
        chk("long_cnt", {cnt_samples, cnt_err}, {4'd2, 4'd2});
        send(8'hA0, 1'b0);
        send(8'h60, 1'b0);
        send(8'hE0, 1'b1);
        wait_mvalid(n);
        chk("after_long_ops", {input_a, input_b, input_c}, {3'd5, 3'd3, 3'd7});
        chk("after_long_class", bus.m_class, 1);
        wait_idle();
        chk("after_long_cnt", {cnt_samples, cnt_err}, {4'd3, 4'd2});

        // Backpressure
        mr_mode = 2;
        send(8'h60, 1'b0);
        send(8'h60, 1'b0);
        send(8'h60, 1'b1);
        wait_mvalid(n);
        chk("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.m_valid, 1);
            chk("bp_s_ready", bus.s_ready, 0);
            chk("bp_result", {bus.m_class, bus.m_err}, 2'b10);
        end
        mr_mode = 1;
        wait_idle();
        @(negedge clk);
        chk("bp_cnt", {cnt_samples, cnt_err}, {4'd4, 4'd2});

        // Reset while settling
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_s_ready", bus.s_ready, 1);
        chk("mrst_outs", {bus.m_valid, bus.m_class, bus.m_err}, 0);
        chk("mrst_ops", {input_a, input_b, input_c}, 0);
        chk("mrst_cnt", {cnt_samples, cnt_err}, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_no_result", bus.m_valid, 0);
        end

        // Random traffic
        mr_mode = 0;
        for (int f = 0; f < 250; f++) begin
            r = int'($urandom_range(0, 9));
            len = (r < 6) ? 3 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 4 : 5;
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(8'($urandom_range(0, 255)), 1'(b == len - 1));
            end
        end
        mr_mode = 1;
        wait_idle();
        chk("final_sat_samples", cnt_samples, SAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
